// File: rtl/strokie_arbiter.sv
// strokie_arbiter: two-requester round-robin arbiter and sequencer for the
// shared strokie FP unit. It grants one requester, issues a one-cycle start,
// waits for the unit (bounded by a watchdog) and returns the result over a
// per-requester valid/ready response channel. One operation is in flight.

// Per-requester response holding register: loads on completion, drops on handshake.
module strokie_arb_rsp (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_load,
    input  logic [31:0] i_result,
    input  logic [4:0]  i_flags,
    input  logic        i_timeout,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_flags,
    output logic        o_timeout
);

    // Valid rises on load and falls on the consuming handshake; data holds meanwhile.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_flags   <= '0;
            o_timeout <= 1'b0;
        end else if (i_load) begin
            o_valid   <= 1'b1;
            o_result  <= i_result;
            o_flags   <= i_flags;
            o_timeout <= i_timeout;
        end else if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
        end
    end

endmodule

module strokie_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        R0_REQ_VALID,
    output logic        R0_REQ_READY,
    input  logic [31:0] R0_OP_A,
    input  logic [31:0] R0_OP_B,
    input  logic [2:0]  R0_OP_CODE,
    input  logic        R0_MODE_FP,
    input  logic        R0_ROUND_MODE,
    output logic        R0_RSP_VALID,
    input  logic        R0_RSP_READY,
    output logic [31:0] R0_RSP_RESULT,
    output logic [4:0]  R0_RSP_FLAGS,
    output logic        R0_RSP_TIMEOUT,

    input  logic        R1_REQ_VALID,
    output logic        R1_REQ_READY,
    input  logic [31:0] R1_OP_A,
    input  logic [31:0] R1_OP_B,
    input  logic [2:0]  R1_OP_CODE,
    input  logic        R1_MODE_FP,
    input  logic        R1_ROUND_MODE,
    output logic        R1_RSP_VALID,
    input  logic        R1_RSP_READY,
    output logic [31:0] R1_RSP_RESULT,
    output logic [4:0]  R1_RSP_FLAGS,
    output logic        R1_RSP_TIMEOUT,

    output logic [31:0] U_OP_A,
    output logic [31:0] U_OP_B,
    output logic [2:0]  U_OP_CODE,
    output logic        U_MODE_FP,
    output logic        U_ROUND_MODE,
    output logic        U_START,
    input  logic [31:0] U_RESULT,
    input  logic [4:0]  U_FLAGS,
    input  logic        U_VALID_OUT,

    output logic        BUSY
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t          r_state, w_next;
    logic            r_last_grant;
    logic            r_grant;
    logic [CW-1:0]   r_cnt;

    logic            w_gnt;
    logic            w_accept;
    logic            w_active;
    logic            w_done;
    logic            w_tmo;
    logic            w_rsp_hs;
    logic [1:0]      w_rsp_ready;
    logic [1:0]      w_load;
    logic [31:0]     w_fin_result;
    logic [4:0]      w_fin_flags;

    logic [1:0]           w_rsp_valid;
    logic [1:0][31:0]     w_rsp_result;
    logic [1:0][4:0]      w_rsp_flags;
    logic [1:0]           w_rsp_timeout;

    assign w_rsp_ready = {R1_RSP_READY, R0_RSP_READY};
    assign w_accept    = (r_state == ST_IDLE) && (R0_REQ_VALID || R1_REQ_VALID);
    assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_done      = w_active && U_VALID_OUT;
    // A completion on the watchdog's last cycle takes priority over the abort.
    assign w_tmo       = w_active && !U_VALID_OUT && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_rsp_hs    = (r_state == ST_RESP) && w_rsp_ready[r_grant];

    assign R0_REQ_READY = w_accept && !w_gnt;
    assign R1_REQ_READY = w_accept &&  w_gnt;

    // Round-robin pick: a lone requester wins, a contest goes to the one not served last.
    always_comb begin
        w_gnt = 1'b0;
        if (R0_REQ_VALID && R1_REQ_VALID) w_gnt = ~r_last_grant;
        else if (R1_REQ_VALID)            w_gnt = 1'b1;
    end

    // Next-state logic for the single-operation sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:          if (w_accept) w_next = ST_ISSUE;
            ST_ISSUE, ST_WAIT: w_next = (w_done || w_tmo) ? ST_RESP : ST_WAIT;
            ST_RESP:          if (w_rsp_hs) w_next = ST_IDLE;
            default:          w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Unit drive, watchdog counter and grant bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            U_OP_A       <= '0;
            U_OP_B       <= '0;
            U_OP_CODE    <= '0;
            U_MODE_FP    <= 1'b0;
            U_ROUND_MODE <= 1'b0;
            U_START      <= 1'b0;
            BUSY         <= 1'b0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            U_START <= w_accept;
            BUSY    <= (w_next != ST_IDLE);
            if (w_accept) begin
                U_OP_A       <= w_gnt ? R1_OP_A       : R0_OP_A;
                U_OP_B       <= w_gnt ? R1_OP_B       : R0_OP_B;
                U_OP_CODE    <= w_gnt ? R1_OP_CODE    : R0_OP_CODE;
                U_MODE_FP    <= w_gnt ? R1_MODE_FP    : R0_MODE_FP;
                U_ROUND_MODE <= w_gnt ? R1_ROUND_MODE : R0_ROUND_MODE;
                r_grant      <= w_gnt;
                r_cnt        <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_rsp_hs) r_last_grant <= r_grant;
        end
    end

    // Route the finished operation (or the abort) to the granted requester's slot.
    always_comb begin
        w_load       = '0;
        w_fin_result = w_done ? U_RESULT : '0;
        w_fin_flags  = w_done ? U_FLAGS  : '0;
        if (w_done || w_tmo) w_load[r_grant] = 1'b1;
    end

    for (genvar n = 0; n < 2; n++) begin : g_rsp
        strokie_arb_rsp u_rsp (
            .CLK       (CLK),
            .RESET     (RESET),
            .i_load    (w_load[n]),
            .i_result  (w_fin_result),
            .i_flags   (w_fin_flags),
            .i_timeout (!w_done),
            .i_ready   (w_rsp_ready[n]),
            .o_valid   (w_rsp_valid[n]),
            .o_result  (w_rsp_result[n]),
            .o_flags   (w_rsp_flags[n]),
            .o_timeout (w_rsp_timeout[n])
        );
    end

    assign R0_RSP_VALID   = w_rsp_valid[0];
    assign R0_RSP_RESULT  = w_rsp_result[0];
    assign R0_RSP_FLAGS   = w_rsp_flags[0];
    assign R0_RSP_TIMEOUT = w_rsp_timeout[0];
    assign R1_RSP_VALID   = w_rsp_valid[1];
    assign R1_RSP_RESULT  = w_rsp_result[1];
    assign R1_RSP_FLAGS   = w_rsp_flags[1];
    assign R1_RSP_TIMEOUT = w_rsp_timeout[1];

endmodule

// File: tb/tb_strokie_arbiter.sv
// tb_strokie_arbiter: directed scenarios plus randomized traffic. Requests push
// their expected responses into per-requester queues; a negedge monitor checks
// every cycle against a transaction-level model of grant, timing and data.
module tb_strokie_arbiter;

    localparam int TO = 8;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
        logic        to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_valid = '0;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic [2:0]  op_code [2];
    logic [1:0]  mode = '0, rnd = '0;

    logic        r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid;
    logic [31:0] r0_rsp_res, r1_rsp_res;
    logic [4:0]  r0_rsp_flg, r1_rsp_flg;
    logic        r0_rsp_to, r1_rsp_to;
    logic [31:0] u_a, u_b;
    logic [2:0]  u_code;
    logic        u_mode, u_rnd, u_start, busy;
    logic [31:0] u_res = '0;
    logic [4:0]  u_flg = '0;
    logic        u_vout = 1'b0;

    wire [1:0] req_ready = {r1_req_ready, r0_req_ready};
    wire [1:0] rsp_valid = {r1_rsp_valid, r0_rsp_valid};
    logic [37:0] rsp_bus [2];
    assign rsp_bus[0] = {r0_rsp_res, r0_rsp_flg, r0_rsp_to};
    assign rsp_bus[1] = {r1_rsp_res, r1_rsp_flg, r1_rsp_to};

    strokie_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .RESET(rst),
        .R0_REQ_VALID(req_valid[0]), .R0_REQ_READY(r0_req_ready),
        .R0_OP_A(op_a[0]), .R0_OP_B(op_b[0]), .R0_OP_CODE(op_code[0]),
        .R0_MODE_FP(mode[0]), .R0_ROUND_MODE(rnd[0]),
        .R0_RSP_VALID(r0_rsp_valid), .R0_RSP_READY(rsp_ready[0]),
        .R0_RSP_RESULT(r0_rsp_res), .R0_RSP_FLAGS(r0_rsp_flg), .R0_RSP_TIMEOUT(r0_rsp_to),
        .R1_REQ_VALID(req_valid[1]), .R1_REQ_READY(r1_req_ready),
        .R1_OP_A(op_a[1]), .R1_OP_B(op_b[1]), .R1_OP_CODE(op_code[1]),
        .R1_MODE_FP(mode[1]), .R1_ROUND_MODE(rnd[1]),
        .R1_RSP_VALID(r1_rsp_valid), .R1_RSP_READY(rsp_ready[1]),
        .R1_RSP_RESULT(r1_rsp_res), .R1_RSP_FLAGS(r1_rsp_flg), .R1_RSP_TIMEOUT(r1_rsp_to),
        .U_OP_A(u_a), .U_OP_B(u_b), .U_OP_CODE(u_code), .U_MODE_FP(u_mode),
        .U_ROUND_MODE(u_rnd), .U_START(u_start), .U_RESULT(u_res), .U_FLAGS(u_flg),
        .U_VALID_OUT(u_vout), .BUSY(busy)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // ---------------- reference model ----------------
    // Unit latency chosen by op code; 0 means the unit never answers.
    function automatic int lat_of(input logic [2:0] c);
        case (c)
            3'd0: return 3;  3'd1: return 1;  3'd2: return 2;  3'd3: return 5;
            3'd4: return 7;  3'd5: return TO; 3'd6: return TO + 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] f_res(input logic [31:0] a, b, input logic [2:0] c, input logic m, r);
        return (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {c, m, r, 27'd0};
    endfunction

    function automatic logic [4:0] f_flg(input logic [31:0] a, b, input logic [2:0] c, input logic m, r);
        return a[4:0] ^ b[9:5] ^ {c, m, r};
    endfunction

    function automatic bit completes(input logic [2:0] c);
        int l = lat_of(c);
        return (l >= 1) && (l <= TO);
    endfunction

    // Cycle (relative to acceptance) at which the response first appears.
    function automatic int rsp_at(input logic [2:0] c);
        return completes(c) ? lat_of(c) + 1 : TO + 1;
    endfunction

    function automatic rsp_t exp_rsp(input logic [31:0] a, b, input logic [2:0] c, input logic m, r);
        rsp_t e;
        if (completes(c)) e = '{res: f_res(a, b, c, m, r), flg: f_flg(a, b, c, m, r), to: 1'b0};
        else              e = '{res: 32'd0, flg: 5'd0, to: 1'b1};
        return e;
    endfunction

    rsp_t q0[$], q1[$];

    // ---------------- unit model ----------------
    bit spur = 0;
    int rem = 0;
    always @(negedge clk) begin
        u_vout = 1'b0;
        if (u_start) rem = lat_of(u_code);
        if (rem > 0) begin
            if (rem == 1) begin
                u_vout = 1'b1;
                u_res  = f_res(u_a, u_b, u_code, u_mode, u_rnd);
                u_flg  = f_flg(u_a, u_b, u_code, u_mode, u_rnd);
            end
            rem--;
        end else if (spur && !busy && $urandom_range(0, 3) == 0) begin
            u_vout = 1'b1;
            u_res  = $urandom;
            u_flg  = 5'($urandom);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          inflight = 0;
    bit          lg = 1;
    int          acc_cyc = 0, acc_n = 0, acc_at = 0, hs_cyc = 0, hold_n = -1;
    logic [68:0] acc_bus = '0;
    logic [37:0] hold_d = '0;
    int          grant_log[$];
    rsp_t        m_e;
    logic [1:0]  ev, exp_rdy;
    bit          exp_g;

    always @(negedge clk) begin
        if (rst) begin
            inflight = 0;
            lg       = 1;
            hold_n   = -1;
        end else begin
            exp_g   = (req_valid == 2'b11) ? !lg : req_valid[1];
            exp_rdy = (!inflight && req_valid != 2'b00) ? (exp_g ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, inflight);
            chk("u_start", u_start, inflight && (cyc == acc_cyc + 1));
            if (inflight && cyc > acc_cyc)
                chk("u_bus", {u_a, u_b, u_code, u_mode, u_rnd}, acc_bus);
            ev = (inflight && (cyc - acc_cyc) >= acc_at) ? (2'b01 << acc_n) : 2'b00;
            chk("rsp_valid", rsp_valid, ev);
            if (hold_n >= 0) chk("rsp_hold", rsp_bus[hold_n], hold_d);
            hold_n = -1;
            for (int n = 0; n < 2; n++) begin
                if (ev[n] && rsp_valid[n]) begin
                    if (rsp_ready[n]) begin
                        if ((n == 0 ? q0.size() : q1.size()) == 0) begin
                            fail_now("sb_empty");
                        end else begin
                            m_e = (n == 0) ? q0.pop_front() : q1.pop_front();
                            chk(n == 0 ? "rsp0_data" : "rsp1_data", rsp_bus[n], {m_e.res, m_e.flg, m_e.to});
                        end
                        inflight = 0;
                        lg       = n[0];
                        hs_cyc   = cyc;
                    end else begin
                        hold_n = n;
                        hold_d = rsp_bus[n];
                    end
                end
            end
            if (!inflight && (req_valid & req_ready) != 2'b00) begin
                inflight = 1;
                acc_n    = req_ready[1] ? 1 : 0;
                acc_cyc  = cyc;
                acc_at   = rsp_at(op_code[acc_n]);
                acc_bus  = {op_a[acc_n], op_b[acc_n], op_code[acc_n], mode[acc_n], rnd[acc_n]};
                grant_log.push_back(acc_n);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int n, input logic [31:0] a, b, input logic [2:0] c,
                        input logic m, r, output int acc);
        if (n == 0) q0.push_back(exp_rsp(a, b, c, m, r));
        else        q1.push_back(exp_rsp(a, b, c, m, r));
        op_a[n] = a; op_b[n] = b; op_code[n] = c; mode[n] = m; rnd[n] = r;
        req_valid[n] = 1'b1;
        acc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req_ready[n]) begin acc = cyc; break; end
        end
        if (acc < 0) fail_now("req_accept");
        @(posedge clk); #1;
        req_valid[n] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (!inflight && q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00) begin
                ok = 1; break;
            end
        end
        if (!ok) fail_now("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ubus"}, {u_a, u_b, u_code, u_mode, u_rnd, u_start, busy, rsp_valid}, '0);
        chk({nm, "_rsp"}, {rsp_bus[0], rsp_bus[1]}, '0);
    endtask

    initial begin
        int t_acc, t_r0, t_hs, dummy;
        bit done;
        op_a[0] = '0; op_a[1] = '0; op_b[0] = '0; op_b[1] = '0;
        op_code[0] = '0; op_code[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 2'b11;

        // Single request, unit latency 3: response first valid 4 cycles after accept.
        send(0, 32'h0064, 32'h0047, 3'd0, 1'b0, 1'b0, t_acc);
        wait_idle();
        chk("single_lat", hs_cyc - t_acc, 4);

        // Back-pressure on R1 while R0 waits.
        rsp_ready[1] = 1'b0;
        t_hs = 0;
        fork
            send(1, $urandom, $urandom, 3'd1, 1'b1, 1'b0, dummy);
            begin
                @(posedge clk); #1; @(posedge clk); #1;
                send(0, $urandom, $urandom, 3'd2, 1'b0, 1'b1, t_r0);
            end
            begin
                bit seen = 0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (rsp_valid[1]) begin seen = 1; break; end
                end
                if (!seen) fail_now("bp_rsp_valid");
                repeat (10) @(posedge clk);
                #1 rsp_ready[1] = 1'b1;
                @(negedge clk);
                t_hs = cyc;
            end
        join
        wait_idle();
        chk("bp_next_accept", t_r0, t_hs + 1);

        // Watchdog abort, late answer in RESP, and same-cycle completion.
        send(0, $urandom, $urandom, 3'd7, 1'b0, 1'b0, t_acc);
        wait_idle();
        chk("timeout_lat", hs_cyc - t_acc, TO + 1);
        spur = 1;
        repeat (12) @(posedge clk);
        #1 spur = 0;
        send(1, $urandom, $urandom, 3'd6, 1'b1, 1'b1, dummy);
        wait_idle();
        send(0, $urandom, $urandom, 3'd5, 1'b1, 1'b0, t_acc);
        wait_idle();
        chk("same_cycle_lat", hs_cyc - t_acc, TO + 1);

        // Reset while waiting on the unit: outputs clear, no response, then R0 wins.
        send(1, $urandom, $urandom, 3'd4, 1'b0, 1'b1, dummy);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        repeat (8) @(posedge clk);
        #1 grant_log.delete();
        fork
            for (int i = 0; i < 2; i++) send(0, $urandom, $urandom, 3'($urandom_range(0, 2)), 1'b0, 1'b0, dummy);
            for (int j = 0; j < 2; j++) send(1, $urandom, $urandom, 3'($urandom_range(0, 2)), 1'b1, 1'b0, dummy);
        join
        wait_idle();
        chk("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("rr_grant%0d", i), grant_log[i], i % 2);

        // Randomized traffic with random back-pressure and stray unit pulses.
        spur = 1;
        done = 0;
        fork
            begin
                fork
                    for (int i = 0; i < 25; i++) begin
                        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                        send(0, $urandom, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), dummy);
                    end
                    for (int j = 0; j < 25; j++) begin
                        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                        send(1, $urandom, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), dummy);
                    end
                join
                done = 1;
            end
            while (!done) begin
                @(posedge clk); #1;
                rsp_ready = 2'($urandom);
            end
        join
        rsp_ready = 2'b11;
        wait_idle();
        spur = 0;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
